alu_seq_engine: RTL and testbench
=================================

# alu_seq_engine

Parametrised, clocked successor to the combinational ALU ROM stage. It latches operands on a start strobe and executes ADD, AND, OR, XOR and NOT in one cycle. It implements the three spare opcodes as multi-cycle rotate and shift operations, one bit per cycle. The result is held in a register and driven onto the shared IBUS only during a read strobe, together with the L/V flag-set strobes.

## Interface
- `WIDTH`, default 16: data path and IBUS width (≥4).
- `CW`, default $clog2(WIDTH): shift-count width, taken from `b[CW-1:0]`.
- `clk` in 1: system clock, rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `nalu_op` in 1: active-low start; falling edge detected on clk.
- `op` in 3: operation, sampled with start.
- `a`, `b` in WIDTH: operands, sampled with start.
- `fl` in 1: current L flag; carry-in / rotate bit, sampled with start.
- `nread_alu_y` in 1: active-low result read / output enable.
- `ibus` out (tri) WIDTH: result; Z unless driven.
- `busy` out 1: operation in progress.
- `flout` out 1: new L value.
- `nsetl` out 1: active-low L write strobe.
- `fvout` out 1: new V value.
- `nsetv` out 1: active-low V write strobe.

## Operation
- Opcodes:
  - 0: ADD, y=a+b+fl.
  - 1: AND.
  - 2: OR.
  - 3: XOR.
  - 4: NOT a.
  - 5: ROL, rotates {L,a} left through L by n=b[CW-1:0].
  - 6: SRU, logical right shift by n.
  - 7: SRA, arithmetic right shift by n.
- Start: registered `nalu_op` previous value; start = prev 1 and current 0, seen at a clk edge while state ≠ EXEC. Start during EXEC is ignored and not queued. Holding `nalu_op` low does not retrigger.
- FSM states:
  - IDLE: after reset.
  - EXEC: at start, a/b/op/fl are latched and the counter is loaded with n.
  - DONE: result register valid; remains until the next start.
- EXEC, ops 0–4: result written on the first EXEC edge, then → DONE.
- EXEC, ops 5–7: each edge performs one single-bit step and decrements the counter. → DONE on the edge where the counter reaches 0. n=0 takes one edge with no shift; the result equals a, and L is not set.
- Flags:
  - ADD: flout = carry out of bit WIDTH-1. fvout = signed overflow (operand signs equal, result sign differs).
  - ROL/SRU/SRA with n>0: flout = last bit moved out of the data word (ROL: into L).
  - AND/OR/XOR/NOT, and shifts with n=0: flag strobes stay high.
  - V is set by ADD only.
- Read: `ibus` = result register while `nread_alu_y`=0 and state=DONE; otherwise Z. The read does not change state; repeated reads are allowed.
- `nsetl`/`nsetv` go low combinationally only while `nread_alu_y`=0, state=DONE, and the op sets that flag.
- Read in IDLE or EXEC: `ibus` Z, strobes high.

## Timing
- Reset (async, immediate), including mid-EXEC: state IDLE, busy 0, result 0, counter 0, flout 0, fvout 0, nsetl 1, nsetv 1, ibus Z. The operation is aborted with no partial result.
- Start at edge E0: busy=1 after E0. Ops 0–4: DONE and busy=0 after E1. Ops 5–7: DONE after E(max(n,1)).
- Latency from start edge to readable result = max(n,1) cycles for shifts, 1 cycle for ops 0–4.
- A new start in DONE discards the old result; the old result stays readable until the E0 of the new start.
- `ibus` enable and disable are combinational from `nread_alu_y`; the bus is released within the same cycle.

## Structure
- Shared package `alu_pkg`: opcode constants (`ALU_ADD` … `ALU_SRA`), FSM state encoding, a helper that says whether an opcode sets L or V.
- One sub-module, `alu_shift_step`: combinational single-bit ROL/SRU/SRA step (WIDTH+1 bits in, WIDTH+1 bits out). The top level owns the FSM, counter, registers and tristate.

## Test plan
- ADD, WIDTH=16: a=7FFF, b=0001, fl=0 → ibus 8000, flout 0, fvout 1, both strobes low during read. a=FFFF, b=0001, fl=1 → 0001, L=1, V=0.
- Logic sweep: a=F0F0, b=3C3C for ops 1–4 → 3030, FCFC, CCCC, 0F0F; strobes high; busy for exactly 1 cycle.
- ROL: a=8001, fl=0, b=0001 → 0002, L=1, done after 1 cycle. SRA: a=8000, b=0004 → F800, L=0, busy 4 cycles. SRU, same operands → 0800.
- n=0 shift: op 6, a=1234, b=0000 → 1234 after 1 cycle, nsetl stays 1.
- Bus and handshake: `ibus` is Z whenever `nread_alu_y`=1 or state≠DONE. A second `nalu_op` falling edge during a 15-cycle SRA is ignored. `nalu_op` held low after DONE produces no restart.
- Reset mid-op: assert `nreset` on cycle 3 of an SRA with b=000F → busy 0 and ibus Z immediately, no strobes. A following ADD 0001+0001 → 0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and
// small decode helpers used by the top level and the shift step.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_NOT = 3'd4;
  localparam logic [2:0] ALU_ROL = 3'd5;
  localparam logic [2:0] ALU_SRU = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Multi-cycle ops take one edge per bit position.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_ROL) || (op == ALU_SRU) || (op == ALU_SRA);
  endfunction

  // ADD and the shifts produce a new L (shifts only when n > 0).
  function automatic logic op_sets_l(input logic [2:0] op);
    return (op == ALU_ADD) || is_shift_op(op);
  endfunction

  // Only ADD produces an overflow flag.
  function automatic logic op_sets_v(input logic [2:0] op);
    return (op == ALU_ADD);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One single-bit step of ROL/SRU/SRA on the {L, data} word.
// Bit WIDTH of the word is the L bit; it receives the bit moved out.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]     op_i,
  input  logic [WIDTH:0] word_i,
  output logic [WIDTH:0] word_o
);

  // Rotate through L, or shift right with the dropped bit landing in L.
  always_comb begin
    word_o = word_i;
    case (op_i)
      ALU_ROL: word_o = {word_i[WIDTH-1:0], word_i[WIDTH]};
      ALU_SRU: word_o = {word_i[0], 1'b0, word_i[WIDTH-1:1]};
      ALU_SRA: word_o = {word_i[0], word_i[WIDTH-1], word_i[WIDTH-1:1]};
      default: word_o = word_i;
    endcase
  end

endmodule

// File: rtl/alu_seq_engine.sv
// Clocked ALU: latches operands on a falling edge of nalu_op, runs
// single-cycle logic/arithmetic or bit-serial shifts, and holds the result
// for tristate readout onto the shared bus together with the flag strobes.
//
// state | meaning
// IDLE  | nothing computed since reset
// EXEC  | operation running; start requests ignored
// DONE  | result register valid and readable
module alu_seq_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             nalu_op,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             fl,
  input  logic             nread_alu_y,
  output tri   [WIDTH-1:0] ibus,
  output logic             busy,
  output logic             flout,
  output logic             nsetl,
  output logic             fvout,
  output logic             nsetv
);

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  alu_state_e       state_q, state_d;
  logic             nalu_prev_q;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             fl_q, fl_d;
  logic [WIDTH:0]   work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flout_q, flout_d;
  logic             fvout_q, fvout_d;
  logic             setl_q, setl_d;
  logic             setv_q, setv_d;

  logic             start;
  logic             exec_last;
  logic             rd_en;
  logic [WIDTH:0]   sum_w;
  logic             ovf_w;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH:0]   step_w;

  alu_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i   (op_q),
    .word_i (work_q),
    .word_o (step_w)
  );

  // A start is a high-to-low transition of nalu_op outside EXEC.
  assign start = nalu_prev_q && !nalu_op && (state_q != ST_EXEC);

  // Single-cycle ops finish on their first EXEC edge; shifts when the count
  // runs out (n = 0 also finishes on the first edge, without shifting).
  assign exec_last = !is_shift_op(op_q) || (cnt_q <= CNT_ONE);

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EXEC;
      ST_EXEC: if (exec_last) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_EXEC;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy and the read enable gating bus and strobes.
  always_comb begin
    busy  = (state_q == ST_EXEC);
    rd_en = !nread_alu_y && (state_q == ST_DONE);
  end

  // Single-cycle ALU result and ADD flags from the latched operands.
  always_comb begin
    sum_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, fl_q};
    ovf_w = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
    case (op_q)
      ALU_ADD: alu_y = sum_w[WIDTH-1:0];
      ALU_AND: alu_y = a_q & b_q;
      ALU_OR:  alu_y = a_q | b_q;
      ALU_XOR: alu_y = a_q ^ b_q;
      ALU_NOT: alu_y = ~a_q;
      default: alu_y = a_q;
    endcase
  end

  // Datapath next values: operand capture, shift stepping, result commit.
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    fl_d    = fl_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flout_d = flout_q;
    fvout_d = fvout_q;
    setl_d  = setl_q;
    setv_d  = setv_q;

    if (start) begin
      op_d   = op;
      a_d    = a;
      b_d    = b;
      fl_d   = fl;
      work_d = {fl, a};
      cnt_d  = b[CW-1:0];
    end else if (state_q == ST_EXEC) begin
      if (!is_shift_op(op_q)) begin
        res_d   = alu_y;
        flout_d = op_sets_l(op_q) ? sum_w[WIDTH] : 1'b0;
        fvout_d = op_sets_v(op_q) ? ovf_w : 1'b0;
        setl_d  = op_sets_l(op_q);
        setv_d  = op_sets_v(op_q);
      end else if (cnt_q == CNT_ZERO) begin
        // Zero-length shift: pass a through, leave L untouched.
        res_d   = work_q[WIDTH-1:0];
        flout_d = 1'b0;
        fvout_d = 1'b0;
        setl_d  = 1'b0;
        setv_d  = 1'b0;
      end else begin
        work_d = step_w;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_d   = step_w[WIDTH-1:0];
          flout_d = step_w[WIDTH];
          fvout_d = 1'b0;
          setl_d  = op_sets_l(op_q);
          setv_d  = 1'b0;
        end
      end
    end
  end

  // Datapath registers; reset aborts any operation with nothing committed.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nalu_prev_q <= 1'b1;
      op_q        <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      fl_q        <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      flout_q     <= 1'b0;
      fvout_q     <= 1'b0;
      setl_q      <= 1'b0;
      setv_q      <= 1'b0;
    end else begin
      nalu_prev_q <= nalu_op;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fl_q        <= fl_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      flout_q     <= flout_d;
      fvout_q     <= fvout_d;
      setl_q      <= setl_d;
      setv_q      <= setv_d;
    end
  end

  assign ibus  = rd_en ? res_q : {WIDTH{1'bz}};
  assign nsetl = !(rd_en && setl_q);
  assign nsetv = !(rd_en && setv_q);
  assign flout = flout_q;
  assign fvout = fvout_q;

endmodule

// File: tb/tb_alu_seq_engine.sv
// Bench for alu_seq_engine (WIDTH=16): directed vector table, randomized
// ops against an arithmetic reference model, and handshake/reset sequences.
module tb_alu_seq_engine;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         nalu_op = 1'b1;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         fl = 1'b0;
  logic         nread_alu_y = 1'b1;
  tri   [W-1:0] ibus;
  logic         busy, flout, nsetl, fvout, nsetv;

  // Bench-side driver of zeros: reads back zero only if the DUT is off the bus.
  logic         probe_en = 1'b0;
  assign ibus = probe_en ? {W{1'b0}} : {W{1'bz}};

  int vectors = 0;
  int miscompares = 0;

  alu_seq_engine #(.WIDTH(W)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .nalu_op     (nalu_op),
    .op          (op),
    .a           (a),
    .b           (b),
    .fl          (fl),
    .nread_alu_y (nread_alu_y),
    .ibus        (ibus),
    .busy        (busy),
    .flout       (flout),
    .nsetl       (nsetl),
    .fvout       (fvout),
    .nsetv       (nsetv)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         fl;
    logic [W-1:0] y;
    logic         l;
    logic         v;
    logic         nsetl;
    logic         nsetv;
    int           cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_released(input string name);
    probe_en = 1'b1;
    #1;
    chk({name, " bus released"}, {16'h0, ibus}, 32'h0);
    probe_en = 1'b0;
    #1;
  endtask

  // Reference model from the operation definitions, plain arithmetic.
  task automatic model(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic f, output logic [W-1:0] y, output logic l, output logic v,
                       output logic ns_l, output logic ns_v, output int cyc);
    int n;
    logic [16:0] s;
    logic [33:0] x, r;
    n = int'(bb[3:0]);
    y = aa; l = 1'b0; v = 1'b0; ns_l = 1'b1; ns_v = 1'b1;
    cyc = (o <= 3'd4) ? 1 : ((n == 0) ? 1 : n);
    case (o)
      3'd0: begin
        s = {1'b0, aa} + {1'b0, bb} + {16'h0, f};
        y = s[15:0]; l = s[16];
        v = (aa[15] == bb[15]) && (y[15] != aa[15]);
        ns_l = 1'b0; ns_v = 1'b0;
      end
      3'd1: y = aa & bb;
      3'd2: y = aa | bb;
      3'd3: y = aa ^ bb;
      3'd4: y = ~aa;
      3'd5: if (n != 0) begin
        x = {17'h0, f, aa};
        r = (x << n) | (x >> (17 - n));
        y = r[15:0]; l = r[16]; ns_l = 1'b0;
      end
      3'd6: if (n != 0) begin
        y = aa >> n; l = aa[n-1]; ns_l = 1'b0;
      end
      default: if (n != 0) begin
        y = $signed(aa) >>> n; l = aa[n-1]; ns_l = 1'b0;
      end
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic f, input logic [W-1:0] ey,
                        input logic el, input logic ev, input logic ensl, input logic ensv,
                        input int ecyc);
    int cyc;
    cyc = 0;
    @(negedge clk);
    op = o; a = aa; b = bb; fl = f; nalu_op = 1'b0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    nalu_op = 1'b1;
    chk({name, " busy cycles"}, cyc, ecyc);
    chk_released({name, " no read"});
    nread_alu_y = 1'b0;
    #1;
    chk({name, " ibus"}, {16'h0, ibus}, {16'h0, ey});
    chk({name, " strobes"}, {30'h0, nsetl, nsetv}, {30'h0, ensl, ensv});
    if (ensl == 1'b0) chk({name, " flout"}, {31'h0, flout}, {31'h0, el});
    if (ensv == 1'b0) chk({name, " fvout"}, {31'h0, fvout}, {31'h0, ev});
    nread_alu_y = 1'b1;
    #1;
    chk({name, " strobes after read"}, {30'h0, nsetl, nsetv}, 32'h3);
  endtask

  initial begin
    logic [W-1:0] ry;
    logic rl, rv, rsl, rsv;
    int rc, cyc;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    logic rf;

    //          op    a         b         fl    y         L     V     nsetl nsetv cyc
    vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd1, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[3]  = '{3'd2, 16'hF0F0, 16'h3C3C, 1'b1, 16'hFCFC, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[4]  = '{3'd3, 16'hF0F0, 16'h3C3C, 1'b0, 16'hCCCC, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[5]  = '{3'd4, 16'hF0F0, 16'h3C3C, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[6]  = '{3'd5, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{3'd7, 16'h8000, 16'h0004, 1'b0, 16'hF800, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    vecs[8]  = '{3'd6, 16'h8000, 16'h0004, 1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    vecs[9]  = '{3'd6, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[10] = '{3'd5, 16'h0001, 16'h0010, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[11] = '{3'd7, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    vecs[12] = '{3'd5, 16'h8000, 16'h000F, 1'b1, 16'h6000, 1'b0, 1'b0, 1'b0, 1'b1, 15};

    // Reset state, with a read request pending.
    nread_alu_y = 1'b0;
    #2;
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset strobes", {30'h0, nsetl, nsetv}, 32'h3);
    chk("reset flags", {30'h0, flout, fvout}, 32'h0);
    chk_released("reset");
    nread_alu_y = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    nread_alu_y = 1'b0;
    #1;
    chk_released("idle read");
    chk("idle read strobes", {30'h0, nsetl, nsetv}, 32'h3);
    nread_alu_y = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fl,
             vecs[i].y, vecs[i].l, vecs[i].v, vecs[i].nsetl, vecs[i].nsetv, vecs[i].cyc);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 1'($urandom_range(0, 1));
      model(ro, ra, rb, rf, ry, rl, rv, rsl, rsv, rc);
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, rf, ry, rl, rv, rsl, rsv, rc);
    end

    // Second falling edge during a 15-cycle SRA is ignored; nalu_op then stays low.
    @(negedge clk);
    op = 3'd7; a = 16'h8000; b = 16'h000F; fl = 1'b0; nalu_op = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 2) nalu_op = 1'b1;
      if (cyc == 3) begin
        nalu_op = 1'b0; op = 3'd0; a = 16'h0001; b = 16'h0001;
      end
      if (cyc == 5) begin
        nread_alu_y = 1'b0;
        chk_released("read during exec");
        chk("strobes during exec", {30'h0, nsetl, nsetv}, 32'h3);
        nread_alu_y = 1'b1;
      end
      @(negedge clk);
    end
    chk("ignored restart busy cycles", cyc, 15);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("held low no restart %0d", k), {31'h0, busy}, 32'h0);
      @(negedge clk);
    end
    nread_alu_y = 1'b0;
    #1;
    chk("ignored restart ibus", {16'h0, ibus}, 32'hFFFF);
    chk("ignored restart strobes", {30'h0, nsetl, nsetv}, 32'h1);
    chk("ignored restart flout", {31'h0, flout}, 32'h0);
    nread_alu_y = 1'b1;
    #1;
    chk_released("read released");
    nalu_op = 1'b1;

    // Reset in the third cycle of a long SRA.
    @(negedge clk);
    op = 3'd7; a = 16'h8000; b = 16'h000F; nalu_op = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    nalu_op = 1'b1;
    nread_alu_y = 1'b0;
    #1;
    nreset = 1'b0;
    #1;
    chk("mid-op reset busy", {31'h0, busy}, 32'h0);
    chk("mid-op reset strobes", {30'h0, nsetl, nsetv}, 32'h3);
    chk_released("mid-op reset");
    nread_alu_y = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("post reset busy", {31'h0, busy}, 32'h0);
    run_op("add after reset", 3'd0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0,
           1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
